// File: rtl/bram_burst_reader_pkg.sv
// Shared types and constants for the BRAM burst reader.
//   state_e     : burst FSM states (IDLE, READ, DRAIN)
//   BufferDepth : words the skid FIFO can hold
//   MaxInflight : RAM reads that can be outstanding (one-cycle registered read)
package bram_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int BufferDepth = 2;
    localparam int MaxInflight = 1;

endpackage

// File: rtl/bram_read_skid_fifo.sv
// Two-entry FIFO that catches words returning from the RAM so a stalled
// consumer never loses data.
// Ports:
//   i_clk, i_rst_n  : clock, synchronous active-low reset (empties the FIFO)
//   i_push          : write i_push_data this cycle
//   i_push_data     : word to store ({last, data} in the burst reader)
//   i_pop           : remove the head word (ignored when empty)
//   o_head          : current head word
//   o_count         : number of stored words, 0..2
module bram_read_skid_fifo
    import bram_burst_reader_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    // r_entry0 is always the head; entries shift forward on a pop.
    logic [WIDTH-1:0] r_entry0;
    logic [WIDTH-1:0] r_entry1;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_head  = r_entry0;
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_count  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_entry0 <= i_push_data;
                    else                 r_entry1 <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_entry0 <= r_entry1;
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_entry0 <= i_push_data;
                    end else begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // A push into a full FIFO without a simultaneous pop would drop a word.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !w_pop && (r_count == 2'(BufferDepth))));

endmodule

// File: rtl/bram_burst_reader.sv
// Streaming burst read engine for sdp_block_ram. Accepts {address, length}
// commands, walks the RAM read port one address per cycle, absorbs the
// one-cycle registered-read latency and emits the words as a stream.
// Ports:
//   i_clk, i_rst_n                     : clock, synchronous active-low reset
//   i_cmd_valid / o_cmd_ready          : command handshake (ready only in IDLE)
//   i_cmd_address, i_cmd_length        : first address, word count (0 = no-op)
//   o_ram_read_address, i_ram_read_data: RAM read port (data one cycle late)
//   o_data_valid / i_data_ready        : output stream handshake
//   o_data, o_data_last                : stream word and end-of-burst marker
//   o_busy                             : a burst is in progress
//
// Handshakes: a transfer happens in any cycle where valid and ready are both
// high. A producer holding valid keeps its payload stable until the transfer;
// ready may change freely and never depends combinationally on valid.
module bram_burst_reader
    import bram_burst_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_address,
    input  logic [LEN_WIDTH-1:0]  i_cmd_length,
    output logic [ADDR_WIDTH-1:0] o_ram_read_address,
    input  logic [DATA_WIDTH-1:0] i_ram_read_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_last,
    output logic                  o_busy
);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_inflight;       // a read was issued last cycle
    logic                  r_inflight_last;  // ...and it was the final one
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_pop;
    logic                  w_cmd_fire;
    logic [1:0]            w_fifo_count;
    logic [2:0]            w_occupancy;
    logic [DATA_WIDTH:0]   w_head;

    assign o_ram_read_address = r_addr;
    assign w_pop              = o_data_valid & i_data_ready;
    assign w_cmd_fire         = i_cmd_valid & o_cmd_ready;
    assign w_issue_last       = w_issue & (r_remaining == LEN_WIDTH'(1));

    // Words that will occupy the FIFO once this cycle's pop is taken out.
    // Counting the pop lets a stall release refill in the same cycle.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_next = r_state;
        o_cmd_ready  = 1'b0;
        o_busy       = 1'b1;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_cmd_valid && (i_cmd_length != '0)) w_state_next = READ;
            end
            READ: begin
                w_issue = (w_occupancy < 3'(BufferDepth));
                if (w_issue && (r_remaining == LEN_WIDTH'(1))) w_state_next = DRAIN;
            end
            DRAIN: begin
                // Leave as soon as the final word is being popped, so the
                // command port reopens the cycle after last.
                if (!r_inflight && ((w_fifo_count == 2'd0) ||
                                    ((w_fifo_count == 2'd1) && w_pop)))
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            if (w_cmd_fire) begin
                r_addr      <= i_cmd_address;
                r_remaining <= i_cmd_length;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
        end
    end

    // RAM data is captured exactly one cycle after its read was issued.
    bram_read_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, i_ram_read_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count)
    );

    assign o_data_valid = (w_fifo_count != 2'd0);
    assign o_data       = w_head[DATA_WIDTH-1:0];
    // The head entry keeps a stale last flag after draining; mask it.
    assign o_data_last  = o_data_valid & w_head[DATA_WIDTH];

endmodule

// File: tb/tb_bram_burst_reader.sv
// Self-checking bench for bram_burst_reader with a behavioural
// registered-read RAM preloaded with RAM[i] = i*3.
module tb_bram_burst_reader;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 32;

    // ---------------- clock / reset ----------------
    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [AW-1:0] i_cmd_address;
    logic [LW-1:0] i_cmd_length;
    logic [AW-1:0] o_ram_read_address;
    logic [DW-1:0] ram_rd_data;
    logic          o_data_valid;
    logic          i_data_ready;
    logic [DW-1:0] o_data;
    logic          o_data_last;
    logic          o_busy;

    always #5 i_clk = ~i_clk;

    bram_burst_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_cmd_valid        (i_cmd_valid),
        .o_cmd_ready        (o_cmd_ready),
        .i_cmd_address      (i_cmd_address),
        .i_cmd_length       (i_cmd_length),
        .o_ram_read_address (o_ram_read_address),
        .i_ram_read_data    (ram_rd_data),
        .o_data_valid       (o_data_valid),
        .i_data_ready       (i_data_ready),
        .o_data             (o_data),
        .o_data_last        (o_data_last),
        .o_busy             (o_busy)
    );

    // Behavioural sdp_block_ram read port: one-cycle registered read.
    logic [DW-1:0] ram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = DW'(i * 3);
    end
    always @(posedge i_clk) ram_rd_data <= ram_mem[o_ram_read_address];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic          cv;
        logic [AW-1:0] ca;
        logic [LW-1:0] cl;
        logic          rdy;
        logic          e_cr;
        logic          e_busy;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_last;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cv, input int ca, input int cl, input logic rdy,
                                input logic e_cr, input logic e_busy, input logic e_valid,
                                input int e_data, input logic e_last);
        vec_t v;
        v.cv = cv; v.ca = AW'(ca); v.cl = LW'(cl); v.rdy = rdy;
        v.e_cr = e_cr; v.e_busy = e_busy; v.e_valid = e_valid;
        v.e_data = DW'(e_data); v.e_last = e_last;
        return v;
    endfunction

    // ---------------- driver: stream run with scoreboard ----------------
    // mode 0: ready always high, 1: toggling 1,0,1,0..., 2: low in cycles 5..14,
    // 3: random ready.
    function automatic logic ready_at(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            2:       return !(cyc >= 5 && cyc <= 14);
            default: return $urandom_range(0, 1) == 1;
        endcase
    endfunction

    task automatic run_stream(input int start, input int len, input int mode);
        logic [DW:0]   exp_q[$];
        logic [DW:0]   held_word;
        logic          stalled;
        int            cyc;
        int            issued;
        int            popped;
        logic [AW-1:0] prev_addr;
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), ram_mem[(start + i) % DEPTH]});
        stalled   = 1'b0;
        held_word = '0;
        issued    = 0;
        popped    = 0;
        cyc       = 0;
        prev_addr = '0;
        i_cmd_valid   = 1'b1;
        i_cmd_address = AW'(start);
        i_cmd_length  = LW'(len);
        check("cmd_ready_idle", o_cmd_ready, 1);
        while (cyc < 400) begin
            i_data_ready = ready_at(mode, cyc);
            if (cyc > 0 && exp_q.size() == 0 && !o_busy) break;
            if (cyc == 1) begin
                check("addr_latched", o_ram_read_address, start % DEPTH);
                prev_addr = o_ram_read_address;
            end else if (cyc > 1 && o_ram_read_address != prev_addr) begin
                issued++;
                prev_addr = o_ram_read_address;
            end
            if (cyc >= 1) check("outstanding_le2", (issued - popped) <= 2, 1);
            if (stalled)
                check("hold_stable", {o_data_valid, o_data_last, o_data}, {1'b1, held_word});
            if (mode == 0)
                check("valid_timing", o_data_valid, (cyc >= 3) && (cyc <= len + 2));
            // Two words popped, two held in the pipeline: the next fetch
            // address sits four past the start and must not move.
            if (mode == 2 && cyc >= 6 && cyc <= 14)
                check("addr_frozen", o_ram_read_address, (start + 4) % DEPTH);
            if (o_data_valid && i_data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word actual=%0h expected=none", o_data);
                end else begin
                    check("word", {o_data_last, o_data}, exp_q.pop_front());
                end
                popped++;
            end
            stalled   = o_data_valid && !i_data_ready;
            held_word = {o_data_last, o_data};
            next_cycle();
            cyc++;
            i_cmd_valid = 1'b0;
        end
        check("all_words_delivered", exp_q.size(), 0);
        check("idle_after", {o_busy, o_cmd_ready, o_data_valid}, 3'b010);
        if (mode == 0) check("end_cycle", cyc, len + 3);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        i_rst_n       = 1'b0;
        i_cmd_valid   = 1'b0;
        i_cmd_address = '0;
        i_cmd_length  = '0;
        i_data_ready  = 1'b0;
        repeat (2) next_cycle();

        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_addr", o_ram_read_address, 0);
        check("rst_valid", o_data_valid, 0);
        check("rst_last", o_data_last, 0);
        check("rst_data", o_data, 0);
        check("rst_busy", o_busy, 0);
        i_rst_n = 1'b1;

        // addr 4 len 4, then wrap burst back-to-back, then no-ops, then len 1.
        //                cv ca cl rdy  cr busy v  data last
        vecs.push_back(mk(1, 4, 4, 1,   1, 0,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   1, 12, 0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   1, 15, 0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   1, 18, 0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   1, 21, 1));
        vecs.push_back(mk(1, 30, 4, 1,  1, 0,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   1, 90, 0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   1, 93, 0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   1, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   1, 3,  1));
        vecs.push_back(mk(1, 7, 0, 1,   1, 0,   0, 0,  0));
        vecs.push_back(mk(1, 5, 0, 1,   1, 0,   0, 0,  0));
        vecs.push_back(mk(1, 2, 1, 1,   1, 0,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 1,   1, 6,  1));
        vecs.push_back(mk(0, 0, 0, 1,   1, 0,   0, 0,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            i_cmd_valid   = vecs[i].cv;
            i_cmd_address = vecs[i].ca;
            i_cmd_length  = vecs[i].cl;
            i_data_ready  = vecs[i].rdy;
            check($sformatf("vec%0d_cmd_ready", i), o_cmd_ready, vecs[i].e_cr);
            check($sformatf("vec%0d_busy", i), o_busy, vecs[i].e_busy);
            check($sformatf("vec%0d_valid", i), o_data_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_last", i), o_data_last, vecs[i].e_last);
            if (vecs[i].e_valid)
                check($sformatf("vec%0d_data", i), o_data, vecs[i].e_data);
            next_cycle();
        end
        i_cmd_valid = 1'b0;

        run_stream(0, 8, 1);    // toggling backpressure
        run_stream(0, 32, 2);   // full depth with a long stall
        run_stream(17, 20, 3);  // random backpressure across the wrap
        run_stream(6, 3, 0);    // short burst, exact latency

        // Reset mid-burst during the third word, then a fresh burst.
        i_cmd_valid   = 1'b1;
        i_cmd_address = AW'(0);
        i_cmd_length  = LW'(8);
        i_data_ready  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            i_cmd_valid = 1'b0;
        end
        check("mid_word3", {o_data_valid, o_data}, {1'b1, 32'd6});
        i_rst_n = 1'b0;
        next_cycle();
        check("mrst_valid", o_data_valid, 0);
        check("mrst_busy", o_busy, 0);
        check("mrst_cmd_ready", o_cmd_ready, 1);
        check("mrst_addr", o_ram_read_address, 0);
        check("mrst_data", o_data, 0);
        check("mrst_last", o_data_last, 0);
        i_rst_n = 1'b1;
        run_stream(10, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
